// File: rtl/display_scheduler.sv
// Shares the 8-digit hex display between NSRC sources: manual pick, round-robin auto-rotate, or freeze.
// disp, cur_src, grant and tick are all registered; tick is high in the cycle the new source first shows.
module display_scheduler #(
  parameter int NSRC  = 4,
  parameter int SW    = 2,
  parameter int DWELL = 50000000,
  parameter int CW    = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*32-1:0]   src_data,
  input  logic [NSRC-1:0]      src_req,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic                 freeze,
  output logic [31:0]          disp,
  output logic [SW-1:0]        cur_src,
  output logic [NSRC-1:0]      grant,
  output logic                 tick
);

  typedef enum logic [1:0] {MANUAL, ROTATE, HOLD} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx, cnt_base;
  logic [SW-1:0]          src_nx, rr_pick;
  logic                   tick_nx;
  logic                   found;
  int                     idx;
  logic [NSRC-1:0][31:0]  src_w;

  assign src_w = src_data;

  // Round-robin search from cur_src+1; the last candidate is cur_src itself,
  // so with no other requester the display stays put.
  always_comb begin
    rr_pick = cur_src;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = (int'(cur_src) + k) % NSRC;
      if (!found && src_req[idx]) begin
        rr_pick = SW'(idx);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = freeze ? HOLD : (mode ? ROTATE : MANUAL);
    src_nx   = cur_src;
    cnt_nx   = cnt;
    cnt_base = cnt;
    tick_nx  = 1'b0;
    case (state_nx)
      MANUAL: begin
        src_nx = (int'(sel) >= NSRC) ? SW'(NSRC - 1) : sel;
        cnt_nx = '0;
      end
      ROTATE: begin
        // Coming out of MANUAL always grants a full dwell.
        cnt_base = (state == MANUAL) ? '0 : cnt;
        if (cnt_base == CW'(DWELL - 1)) begin
          cnt_nx  = '0;
          tick_nx = 1'b1;
          src_nx  = rr_pick;
        end else begin
          cnt_nx = cnt_base + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MANUAL;
      cnt     <= '0;
      tick    <= 1'b0;
      cur_src <= '0;
      grant   <= NSRC'(1);
      disp    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tick  <= tick_nx;
      if (state_nx != HOLD) begin
        cur_src <= src_nx;
        grant   <= NSRC'(1) << src_nx;
        disp    <= src_w[src_nx];
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with NSRC=4, DWELL=4; inputs change and outputs are sampled on negedge.
module tb_display_scheduler;
  localparam int NSRC = 4, SW = 2, DWELL = 4, CW = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NSRC*32-1:0]  src_data;
  logic [NSRC-1:0]     src_req;
  logic                mode, freeze;
  logic [SW-1:0]       sel;
  logic [31:0]         disp;
  logic [SW-1:0]       cur_src;
  logic [NSRC-1:0]     grant;
  logic                tick;

  int n_chk = 0, n_pass = 0;
  logic seen2;

  display_scheduler #(.NSRC(NSRC), .SW(SW), .DWELL(DWELL), .CW(CW)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_req(src_req),
    .mode(mode), .sel(sel), .freeze(freeze),
    .disp(disp), .cur_src(cur_src), .grant(grant), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input int src, input logic t);
    chk({tag, ".disp"}, disp, d);
    chk({tag, ".cur"}, 32'(cur_src), 32'(src));
    chk({tag, ".grant"}, 32'(grant), 32'(1) << src);
    chk({tag, ".tick"}, 32'(tick), 32'(t));
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_data[i*32 +: 32] = v;
  endtask

  // One dwell period: three quiet cycles then an advance to 'nxt' with a tick.
  task automatic dwell(input string tag, input int cur, input int nxt, input logic [31:0] d_nxt);
    for (int c = 0; c < 3; c++) begin
      step(1);
      seen2 |= grant[2];
      chk({tag, ".hold_cur"}, 32'(cur_src), 32'(cur));
      chk({tag, ".no_tick"}, 32'(tick), 32'd0);
    end
    step(1);
    seen2 |= grant[2];
    chk_out({tag, ".adv"}, d_nxt, nxt, 1'b1);
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; freeze = 1'b0; sel = 2'd2; src_req = '0;
    src_data = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    seen2 = 1'b0;

    // Reset state and manual select
    step(1);
    chk_out("reset", 32'h0, 0, 1'b0);
    reset = 1'b0;
    step(1);
    chk_out("man_sel2", 32'hCCCCCCCC, 2, 1'b0);
    set_src(2, 32'h12345678);
    step(1);
    chk("man_live", disp, 32'h12345678);

    // Rotation over requesters 0,1,3
    sel = 2'd0;
    step(1);
    chk_out("man_sel0", 32'hAAAAAAAA, 0, 1'b0);
    src_req = 4'b1011; mode = 1'b1;
    dwell("rot1", 0, 1, 32'hBBBBBBBB);
    dwell("rot2", 1, 3, 32'hDDDDDDDD);
    dwell("rot3", 3, 0, 32'hAAAAAAAA);
    dwell("rot4", 0, 1, 32'hBBBBBBBB);
    chk("never_grant2", 32'(seen2), 32'd0);

    // No requesters, then only the current one: stays on source 1, still ticks
    src_req = 4'b0000;
    dwell("none1", 1, 1, 32'hBBBBBBBB);
    dwell("none2", 1, 1, 32'hBBBBBBBB);
    src_req = 4'b0010;
    dwell("self1", 1, 1, 32'hBBBBBBBB);

    // Freeze at counter=2 while data changes
    src_req = 4'b1011;
    step(2);
    freeze = 1'b1;
    set_src(1, 32'h55555555);
    set_src(3, 32'h99999999);
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk_out("frz", 32'hBBBBBBBB, 1, 1'b0);
    end
    freeze = 1'b0;
    step(1);
    chk_out("rel1", 32'h55555555, 1, 1'b0);
    step(1);
    chk_out("rel2", 32'h99999999, 3, 1'b1);
    dwell("post", 3, 0, 32'hAAAAAAAA);

    // Mode 1->0 mid-dwell, then 0->1 gives a full dwell
    step(2);
    mode = 1'b0; sel = 2'd3;
    step(1);
    chk_out("to_man", 32'h99999999, 3, 1'b0);
    mode = 1'b1;
    dwell("to_rot", 3, 0, 32'hAAAAAAAA);

    // Reset beats freeze during rotation
    step(1);
    freeze = 1'b1; reset = 1'b1;
    step(1);
    chk_out("rst_frz", 32'h0, 0, 1'b0);
    reset = 1'b0; freeze = 1'b0; mode = 1'b0; sel = 2'd1;
    step(1);
    chk_out("rst_man", 32'h55555555, 1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("man_no_tick", 32'(tick), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
